trig_capture_ctrl: RTL and testbench
====================================

# trig_capture_ctrl

Consumes the single-cycle `trig_flag` pulse from the trigger/force-trigger stage and turns it into a framed ADC capture. It writes decimated ADC samples into a circular dual-port sample RAM, keeps a programmable pre-trigger history, and counts the post-trigger samples. It then presents a completed frame to the readout logic through a done/ack handshake. It sits between the ADC front end, the trigger stage and the readout/host side of the sample RAM.

## Interface
Parameters:
- `ADDR_W`, 10: sample RAM address width; DEPTH = 2^ADDR_W.
- `DATA_W`, 8: ADC sample width.

Ports:
- `ADC_clk` in 1: the only clock. One clock; reset is synchronous and active-high.
- `sys_rst` in 1: synchronous, active-high reset.
- `adc_data` in DATA_W: ADC sample.
- `sample_en` in 1: decimation strobe; when high, `adc_data` is a sample to store.
- `arm` in 1: pulse that starts a capture.
- `pre_len` in ADDR_W: pre-trigger sample count, 0..DEPTH-1. Sampled on an accepted `arm`.
- `trig_flag` in 1: single-cycle trigger pulse.
- `rd_ack` in 1: pulse from readout meaning the frame has been consumed.
- `wr_en` out 1: RAM write enable.
- `wr_addr` out ADDR_W: RAM write address.
- `wr_data` out DATA_W: RAM write data.
- `trig_addr` out ADDR_W: RAM address of the first post-trigger sample.
- `start_addr` out ADDR_W: RAM address of the oldest sample in the frame.
- `done` out 1: frame complete and stable.
- `busy` out 1: high in PRE, WAIT_TRIG and POST.

## Operation
States are IDLE, PRE, WAIT_TRIG, POST and DONE. Reset forces IDLE.

- **IDLE, `arm` = 1:**
  - Latch `pre_len` into `pre_q`.
  - Set `wr_ptr` = 0 and `cnt` = 0.
  - Go to PRE. If `pre_len` = 0, go straight to WAIT_TRIG.
- **PRE:**
  - Each `sample_en` writes one sample, then increments `wr_ptr` and `cnt`.
  - When the write makes `cnt` equal `pre_q`, go to WAIT_TRIG.
  - `trig_flag` is ignored in PRE, because the history is not yet valid.
- **WAIT_TRIG:**
  - Writes continue circularly.
  - On `trig_flag` = 1:
    - Set `trig_addr` to the `wr_ptr` value at that cycle. If `sample_en` is also high, this is the address of the sample written that same cycle.
    - Set `cnt` = 0 and go to POST.
- **POST:**
  - Writes continue. `post_len` = DEPTH − `pre_q`, computed in ADDR_W+1 bits.
  - A sample coincident with the trigger counts as the first post sample.
  - When `cnt` reaches `post_len`, go to DONE.
  - `trig_flag` is ignored in POST.
- **DONE:**
  - On entry, `start_addr` is set to `wr_ptr`. The ring then holds exactly DEPTH samples, and this is the oldest one.
  - `done` = 1.
  - No writes occur.
  - `arm` is ignored.
  - `rd_ack` = 1 clears `done` and goes to IDLE.
- **`arm` outside IDLE:** ignored.
- **`rd_ack` outside DONE:** ignored.
- **Pointer wrap:** `wr_ptr` wraps from DEPTH-1 to 0, modulo 2^ADDR_W, with no stall.
- **Reset (power-up or mid-capture):** same cycle's edge gives state IDLE and all outputs 0: `wr_en`, `wr_addr`, `wr_data`, `trig_addr`, `start_addr`, `done`, `busy`. The RAM contents are not cleared.
- **`pre_len` changes mid-capture:** no effect, because `pre_q` is already latched.

## Timing
- **Write latency:** `sample_en` at edge n produces `wr_en`, `wr_addr` and `wr_data` registered and valid for one cycle after edge n+1.
- **Write gating:** `wr_en` is never high in IDLE or DONE. A `sample_en` arriving in the same cycle as an accepted `arm` is not written.
- **`trig_addr`:** registered and valid from the cycle after `trig_flag`. It holds until the next accepted `arm`.
- **`done` and `start_addr`:** both rise on the cycle the last POST write is presented on `wr_en`. They are stable until `rd_ack`.
- **`busy`:** registered. It rises the cycle after an accepted `arm` and falls when `done` rises.
- **`trig_flag` and POST entry:** `trig_flag` in the same cycle as the PRE→WAIT_TRIG transition write is ignored. POST entry requires state = WAIT_TRIG at that edge.
- **Throughput:** one sample per clock is supported (`sample_en` tied high).

## Structure
- **Shared package `capture_pkg`:**
  - State enum `cap_state_t`.
  - Default `ADDR_W` and `DATA_W`.
  - The `post_len` helper function.
  - The package is shared with the readout block so that it computes `start_addr` arithmetic identically.
- **Sub-module `cap_ring_ptr`:**
  - Contents: the wrapping write pointer plus the `cnt` counter.
  - Inputs: clear and sample-enable.
  - Outputs: `wr_ptr` and a compare-match against a supplied limit.
- **Top-level contents:** the FSM and the output registers.

## Test plan
All scenarios use ADDR_W = 4 (DEPTH = 16) unless stated.

- **Full-rate capture:** reset; `sample_en` = 1; `adc_data` increments from 0; `arm` with `pre_len` = 4; `trig_flag` 10 cycles after `arm`.
  - `trig_addr` = 10; exactly 12 post writes; `done` with `start_addr` = 6 (22 mod 16); wraps observed.
- **Zero pre-trigger:** `pre_len` = 0; `trig_flag` on the first cycle after `arm`.
  - Immediate WAIT_TRIG; `trig_addr` = 0; 16 post writes; `start_addr` = 0.
- **Trigger during PRE:** `pre_len` = 8; `trig_flag` pulses at pre `cnt` = 3 and again at 12.
  - The first pulse is ignored; `trig_addr` = 12.
- **Decimated input:** `sample_en` every 4th cycle.
  - `wr_en` pulses are spaced 4 apart, each one cycle after its `sample_en`; `done` only after 16 − `pre_len` post samples.
- **Handshake:**
  - `arm` in DONE: ignored; `done` stays 1.
  - `rd_ack`: `done` = 0 next cycle.
  - A new `arm`: restarts with `wr_ptr` = 0.
- **Reset mid-POST:** assert `sys_rst` for one cycle.
  - Next cycle all outputs are 0 and the state is IDLE.
  - `trig_flag` alone, without `arm`, produces no writes.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared capture definitions: FSM states, default widths and frame arithmetic.
package capture_pkg;

    localparam int unsigned CAP_ADDR_W = 10;
    localparam int unsigned CAP_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_t;

    // Post-trigger sample count of a frame: ring depth minus the pre-trigger history.
    function automatic logic [31:0] calc_post_len(input logic [31:0] pre_q,
                                                  input int unsigned addr_w);
        return (32'd1 << addr_w) - pre_q;
    endfunction

endpackage

// File: rtl/cap_ring_ptr.sv
// Wrapping sample-RAM write pointer plus frame sample counter with limit compare.
module cap_ring_ptr #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              ADC_clk,
    input  logic              sys_rst,
    input  logic              clr,
    input  logic              step,
    input  logic              cnt_en,
    input  logic              cnt_zero,
    input  logic [ADDR_W:0]   limit,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              hit_c
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_base_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // cnt_zero restarts the count so a coincident sample becomes count 1.
    assign cnt_base_c = cnt_zero ? '0 : cnt;
    assign cnt_inc_c  = cnt_base_c + CNT_W'(1);
    assign hit_c      = step && cnt_en && (cnt_inc_c == limit);

    // Pointer wraps naturally modulo 2^ADDR_W; counter only moves when enabled.
    always_ff @(posedge ADC_clk) begin
        if (sys_rst || clr) begin
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (step) begin
                wr_ptr <= ADDR_W'(wr_ptr + ADDR_W'(1));
            end
            if (cnt_en) begin
                cnt <= step ? cnt_inc_c : cnt_base_c;
            end
        end
    end

endmodule

// File: rtl/trig_capture_ctrl.sv
// Framed ADC capture controller: pre-trigger history, post-trigger count, done/ack handoff.
module trig_capture_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W = CAP_ADDR_W,
    parameter int unsigned DATA_W = CAP_DATA_W
) (
    input  logic              ADC_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              sample_en,
    input  logic              arm,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic              trig_flag,
    input  logic              rd_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic              done,
    output logic              busy
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    cap_state_t        state_q;
    cap_state_t        state_d;
    logic [ADDR_W-1:0] pre_q;
    logic [CNT_W-1:0]  post_len;
    logic [CNT_W-1:0]  limit_c;
    logic [ADDR_W-1:0] wr_ptr;
    logic              arm_ok_c;
    logic              step_c;
    logic              cnt_en_c;
    logic              trig_ok_c;
    logic              hit_c;
    logic              enter_done_c;

    assign post_len = CNT_W'(calc_post_len(32'(pre_q), ADDR_W));

    // Datapath controls decoded from the current state only.
    assign arm_ok_c     = (state_q == ST_IDLE) && arm;
    assign step_c       = sample_en && (state_q inside {ST_PRE, ST_WAIT_TRIG, ST_POST});
    assign trig_ok_c    = (state_q == ST_WAIT_TRIG) && trig_flag;
    assign cnt_en_c     = (state_q == ST_PRE) || (state_q == ST_POST) || trig_ok_c;
    assign limit_c      = (state_q == ST_PRE) ? {1'b0, pre_q} : post_len;
    assign enter_done_c = (state_d == ST_DONE) && (state_q != ST_DONE);

    cap_ring_ptr #(
        .ADDR_W (ADDR_W)
    ) u_ring_ptr (
        .ADC_clk  (ADC_clk),
        .sys_rst  (sys_rst),
        .clr      (arm_ok_c),
        .step     (step_c),
        .cnt_en   (cnt_en_c),
        .cnt_zero (trig_ok_c),
        .limit    (limit_c),
        .wr_ptr   (wr_ptr),
        .hit_c    (hit_c)
    );

    // State register.
    always_ff @(posedge ADC_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a trigger whose coincident sample completes the frame skips POST.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = (pre_len == '0) ? ST_WAIT_TRIG : ST_PRE;
                end
            end
            ST_PRE: begin
                if (hit_c) begin
                    state_d = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (trig_flag) begin
                    state_d = hit_c ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (hit_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rd_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered RAM write port, frame addresses and status flags.
    always_ff @(posedge ADC_clk) begin
        if (sys_rst) begin
            pre_q      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_en <= step_c;
            if (step_c) begin
                wr_addr <= wr_ptr;
                wr_data <= adc_data;
            end
            if (arm_ok_c) begin
                pre_q     <= pre_len;
                trig_addr <= '0;
            end
            if (trig_ok_c) begin
                trig_addr <= wr_ptr;
            end
            // Frame always completes on a write, so the oldest sample is the next slot.
            if (enter_done_c) begin
                start_addr <= ADDR_W'(wr_ptr + ADDR_W'(1));
            end
            done <= (state_d == ST_DONE);
            busy <= (state_d inside {ST_PRE, ST_WAIT_TRIG, ST_POST});
        end
    end

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Self-checking bench for trig_capture_ctrl with a sample-count reference model.
module tb_trig_capture_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int          DEPTH = 16;

    logic          ADC_clk;
    logic          sys_rst;
    logic [DW-1:0] adc_data;
    logic          sample_en;
    logic          arm;
    logic [AW-1:0] pre_len;
    logic          trig_flag;
    logic          rd_ack;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;
    logic          done;
    logic          busy;

    trig_capture_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .ADC_clk    (ADC_clk),
        .sys_rst    (sys_rst),
        .adc_data   (adc_data),
        .sample_en  (sample_en),
        .arm        (arm),
        .pre_len    (pre_len),
        .trig_flag  (trig_flag),
        .rd_ack     (rd_ack),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .trig_addr  (trig_addr),
        .start_addr (start_addr),
        .done       (done),
        .busy       (busy)
    );

    initial begin
        ADC_clk = 1'b0;
        forever #5 ADC_clk = ~ADC_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a capture is the number of samples stored since arm,
    // plus the sample index at which the trigger was accepted.
    bit            m_armed    = 1'b0;
    bit            m_complete = 1'b0;
    int            m_nw       = 0;
    int            m_tidx     = -1;
    int            m_pre      = 0;
    bit            e_full     = 1'b0;
    bit            e_wr_en    = 1'b0;
    logic [AW-1:0] e_wr_addr  = '0;
    logic [DW-1:0] e_wr_data  = '0;
    logic [AW-1:0] e_trig     = '0;
    logic [AW-1:0] e_start    = '0;
    bit            e_done     = 1'b0;
    bit            e_busy     = 1'b0;

    int            cyc          = 0;
    int            post_wr      = 0;
    int            wrap_cnt     = 0;
    logic [AW-1:0] prev_wr_addr = '0;
    bit            dec_mode     = 1'b0;
    int            last_wr_cyc  = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        e_full  = 1'b0;
        e_wr_en = 1'b0;
        if (sys_rst) begin
            m_armed = 1'b0; m_complete = 1'b0; e_full = 1'b1;
            e_wr_addr = '0; e_wr_data = '0; e_trig = '0; e_start = '0;
        end else if (!m_armed) begin
            if (arm) begin
                m_armed = 1'b1; m_complete = 1'b0;
                m_nw = 0; m_tidx = -1; m_pre = int'(pre_len);
                e_trig = '0;
            end
        end else if (m_complete) begin
            if (rd_ack) begin
                m_armed = 1'b0; m_complete = 1'b0;
            end
        end else begin
            if (trig_flag && m_tidx < 0 && m_nw >= m_pre) begin
                m_tidx = m_nw;
                e_trig = AW'(m_nw % DEPTH);
            end
            if (sample_en) begin
                e_wr_en   = 1'b1;
                e_wr_addr = AW'(m_nw % DEPTH);
                e_wr_data = adc_data;
                m_nw++;
            end
            if (m_tidx >= 0 && (m_nw - m_tidx) >= (DEPTH - m_pre)) begin
                m_complete = 1'b1;
                e_start    = AW'(m_nw % DEPTH);
            end
        end
        e_done = m_armed && m_complete;
        e_busy = m_armed && !m_complete;
    endtask

    task automatic check_outputs();
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_wr_en || e_full) begin
            chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
            chk("wr_data", 32'(wr_data), 32'(e_wr_data));
        end
        if (e_done || e_full) chk("start_addr", 32'(start_addr), 32'(e_start));
        if ((m_armed && m_tidx >= 0) || e_full) chk("trig_addr", 32'(trig_addr), 32'(e_trig));
        if (wr_en === 1'b1) begin
            post_wr++;
            if (wr_addr == '0 && prev_wr_addr == AW'(DEPTH - 1)) wrap_cnt++;
            prev_wr_addr = wr_addr;
            if (dec_mode) begin
                if (last_wr_cyc >= 0) chk("dec_gap", 32'(cyc - last_wr_cyc), 32'd4);
                last_wr_cyc = cyc;
            end
        end
    endtask

    task automatic step();
        @(posedge ADC_clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
    endtask

    initial begin
        sys_rst = 1'b1; adc_data = '0; sample_en = 1'b0; arm = 1'b0;
        pre_len = '0; trig_flag = 1'b0; rd_ack = 1'b0;
        step(); step();
        sys_rst = 1'b0;

        // Full-rate capture, pre_len 4, trigger when ten samples are stored.
        sample_en = 1'b1;
        arm = 1'b1; pre_len = 4'd4; step(); adc_data++; arm = 1'b0;
        repeat (10) begin step(); adc_data++; end
        trig_flag = 1'b1; post_wr = 0; wrap_cnt = 0; step(); adc_data++; trig_flag = 1'b0;
        for (int i = 0; i < 200 && !m_complete; i++) begin step(); adc_data++; end
        chk("s1_done_reached", 32'(done), 32'd1);
        chk("s1_trig_addr", 32'(trig_addr), 32'd10);
        chk("s1_start_addr", 32'(start_addr), 32'd6);
        chk("s1_post_writes", 32'(post_wr), 32'd12);
        chk("s1_wrapped", 32'(wrap_cnt > 0), 32'd1);

        // Handshake: arm in DONE is ignored, rd_ack releases the frame.
        arm = 1'b1; pre_len = 4'd3; step(); arm = 1'b0;
        chk("hs_done_hold", 32'(done), 32'd1);
        rd_ack = 1'b1; step(); rd_ack = 1'b0;
        chk("hs_done_clr", 32'(done), 32'd0);

        // Zero pre-trigger: re-arm restarts at address 0, trigger right away.
        arm = 1'b1; pre_len = 4'd0; step(); adc_data++; arm = 1'b0;
        trig_flag = 1'b1; post_wr = 0; step(); adc_data++; trig_flag = 1'b0;
        chk("s2_first_addr", 32'(wr_addr), 32'd0);
        for (int i = 0; i < 200 && !m_complete; i++) begin step(); adc_data++; end
        chk("s2_trig_addr", 32'(trig_addr), 32'd0);
        chk("s2_start_addr", 32'(start_addr), 32'd0);
        chk("s2_post_writes", 32'(post_wr), 32'd16);
        rd_ack = 1'b1; step(); rd_ack = 1'b0;

        // Trigger during PRE is ignored; second pulse at sample 12 is taken.
        arm = 1'b1; pre_len = 4'd8; step(); adc_data++; arm = 1'b0;
        repeat (3) begin step(); adc_data++; end
        trig_flag = 1'b1; step(); adc_data++; trig_flag = 1'b0;
        repeat (8) begin step(); adc_data++; end
        trig_flag = 1'b1; post_wr = 0; step(); adc_data++; trig_flag = 1'b0;
        for (int i = 0; i < 200 && !m_complete; i++) begin step(); adc_data++; end
        chk("s3_trig_addr", 32'(trig_addr), 32'd12);
        chk("s3_start_addr", 32'(start_addr), 32'd4);
        chk("s3_post_writes", 32'(post_wr), 32'd8);
        rd_ack = 1'b1; step(); rd_ack = 1'b0;

        // Decimated input: one sample every fourth cycle.
        dec_mode = 1'b1; last_wr_cyc = -1;
        sample_en = ((cyc % 4) == 0);
        arm = 1'b1; pre_len = 4'd5; step(); arm = 1'b0;
        sample_en = ((cyc % 4) == 0);
        repeat (60) begin
            adc_data = DW'($urandom); step(); sample_en = ((cyc % 4) == 0);
        end
        trig_flag = 1'b1; post_wr = 0; step(); trig_flag = 1'b0; sample_en = ((cyc % 4) == 0);
        for (int i = 0; i < 400 && !m_complete; i++) begin
            adc_data = DW'($urandom); step(); sample_en = ((cyc % 4) == 0);
        end
        chk("dec_done_reached", 32'(done), 32'd1);
        chk("dec_post_writes", 32'(post_wr), 32'd11);
        dec_mode = 1'b0;
        rd_ack = 1'b1; step(); rd_ack = 1'b0;

        // Randomized traffic, pre_len churning every cycle.
        for (int i = 0; i < 800; i++) begin
            sample_en = ($urandom_range(0, 3) != 0);
            adc_data  = DW'($urandom);
            pre_len   = AW'($urandom_range(0, DEPTH - 1));
            arm       = ($urandom_range(0, 7) == 0);
            trig_flag = ($urandom_range(0, 9) == 0);
            rd_ack    = ($urandom_range(0, 5) == 0);
            step();
        end
        arm = 1'b0; trig_flag = 1'b0; rd_ack = 1'b0;

        // Reset in the middle of POST.
        sys_rst = 1'b1; step(); sys_rst = 1'b0;
        sample_en = 1'b1;
        arm = 1'b1; pre_len = 4'd2; step(); adc_data++; arm = 1'b0;
        repeat (3) begin step(); adc_data++; end
        trig_flag = 1'b1; step(); adc_data++; trig_flag = 1'b0;
        repeat (2) begin step(); adc_data++; end
        chk("rst_in_post_busy", 32'(busy), 32'd1);
        sys_rst = 1'b1; step(); sys_rst = 1'b0;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_trig_addr", 32'(trig_addr), 32'd0);
        chk("rst_start_addr", 32'(start_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        post_wr = 0;
        repeat (6) begin trig_flag = ~trig_flag; step(); adc_data++; end
        trig_flag = 1'b0;
        chk("idle_trig_no_writes", 32'(post_wr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
